gate_sweep_ctrl: RTL and testbench
==================================

// Module: gate_sweep_ctrl
// PURPOSE
//   Sequencer for a 2-input logic-gate datapath unit (A, B -> Y). On start, drives all four
//   input combinations {A,B}=00,01,10,11 in order, waits a settle time per combination,
//   samples Y, and compares the captured truth table against an expected one. Sits between
//   the lab control logic / board switches and one gate instance; reports pass/fail per sweep.
// PARAMETERS
//   SETTLE_CYCLES  2  cycles each combination is driven before Y is sampled (legal >= 1)
//   ERR_W          8  width of the failing-sweep counter (only with GATE_SWEEP_ERRCNT_EN)
// PORTS
//   clk          in   1      system clock, all logic on rising edge
//   rst          in   1      synchronous, active-high reset
//   start        in   1      request a sweep; accepted only in IDLE
//   expected_tt  in   4      expected Y; bit i = Y for A=i[1], B=i[0]; latched at start accept
//   gate_a       out  1      A input to the gate under control
//   gate_b       out  1      B input to the gate under control
//   gate_y       in   1      Y output of the gate under control
//   busy         out  1      high in DRIVE, SAMPLE, FINISH
//   done         out  1      one-cycle pulse in FINISH
//   pass         out  1      result_tt == expected; valid from done, held until next start accept
//   result_tt    out  4      captured Y per combination, same bit mapping as expected_tt
//   mismatch     out  4      result_tt ^ expected; updated in FINISH, held like pass
//   err_count    out  ERR_W  failing sweeps since reset (port exists only with the macro)
// BEHAVIOUR
//   Reset: state=IDLE; gate_a=gate_b=0; busy=done=pass=0; result_tt=mismatch=0; idx=0; err_count=0.
//   States: IDLE -> DRIVE -> SAMPLE -> (DRIVE | FINISH) -> IDLE.
//   IDLE: gate_a/b=0. start=1 -> latch expected_tt, idx=0, settle_cnt=0, clear result_tt, -> DRIVE.
//   DRIVE: gate_a=idx[1], gate_b=idx[0]; settle_cnt counts to SETTLE_CYCLES-1, then -> SAMPLE.
//   SAMPLE: inputs still driven; result_tt[idx]<=gate_y; idx==3 -> FINISH, else idx++, settle_cnt=0, -> DRIVE.
//   FINISH: done=1 for this cycle only; pass/mismatch registered from completed table;
//     gate_a/b return to 0; -> IDLE unconditionally.
//   Latency: done asserted 4*(SETTLE_CYCLES+1)+1 edges after the edge that accepts start
//     (13 for default). Back-to-back: start held high re-arms on the IDLE cycle after FINISH.
//   start while busy (incl. FINISH) is ignored, not queued. expected_tt changes mid-sweep ignored.
//   idx is 2 bits; sweep ends at idx==3, never wraps. pass/mismatch cleared to 0 on start accept.
//   rst mid-sweep: immediate return to reset values next edge; no done pulse for aborted sweep.
// CONFIGURATION
//   GATE_SWEEP_ERRCNT_EN defined: err_count port present; +1 in FINISH when pass would be 0,
//     saturates at all-ones, cleared only by rst.
//   Not defined: port and counter absent; all other behaviour identical.
// STRUCTURE
//   gate_sweep_pkg: state enum typedef (IDLE, DRIVE, SAMPLE, FINISH), NUM_COMBOS=4, IDX_W=2.
//   Sub-module settle_timer: loadable down/up counter with SETTLE_CYCLES param and 'expired'
//   output; FSM, capture and compare stay in gate_sweep_ctrl.
// TESTING
//   1 AND model on gate, expected_tt=4'b1000, 1-cycle start -> gate_a/b step 00,01,10,11;
//     done at edge 13; pass=1, result_tt=1000, mismatch=0000.
//   2 gate_y tied 0, expected_tt=1000 -> pass=0, mismatch=1000; err_count=1 (macro on).
//   3 start pulsed again at edge 5 of a sweep -> exactly one done, no second sweep.
//   4 rst at edge 7 mid-sweep -> next cycle busy=0, gate_a/b=0, result_tt=0, no done;
//     new start afterwards completes normally with done at edge 13.
//   5 OR model, SETTLE_CYCLES=1, expected_tt=1110 -> done at edge 9, pass=1.
//   6 ERR_W=2, macro on, five failing sweeps with start held high -> err_count=3 (saturated),
//     done pulses separated by exactly one IDLE cycle.

Source files
------------

// File: rtl/gate_sweep_pkg.sv
// -----------------------------------------------------------------------------
// gate_sweep_pkg
//   Shared types and constants for the 2-input gate sweep sequencer:
//   the FSM state enum, the number of input combinations, and the index width.
//   Optional feature macro used by the files that import this package:
//     GATE_SWEEP_ERRCNT_EN  adds the saturating failing-sweep counter.
// -----------------------------------------------------------------------------
package gate_sweep_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRIVE  = 2'd1,
      SAMPLE = 2'd2,
      FINISH = 2'd3
   } sweep_state_e;

   localparam int NUM_COMBOS = 4;
   localparam int IDX_W      = 2;

   // Index of the last combination; the sweep ends here instead of wrapping.
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COMBOS - 1);

endpackage

// File: rtl/gate_sweep_ctrl_settle_timer.sv
// -----------------------------------------------------------------------------
// settle_timer
//   Counts the cycles a gate input combination has been driven. The count is
//   held at zero while 'clear' is high and advances while 'enable' is high,
//   stopping at SETTLE_CYCLES-1. 'expired' is high on the last settle cycle,
//   so the owner sees exactly SETTLE_CYCLES enabled cycles per combination.
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   clear    in   force count to zero
//   enable   in   advance count
//   expired  out  current cycle is the final settle cycle
// -----------------------------------------------------------------------------
module settle_timer #(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   // At least one bit even when SETTLE_CYCLES==1 (count then sits at 0).
   localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign expired = (cnt_q == LAST_CNT);

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && !expired) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/gate_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// gate_sweep_ctrl
//   Drives {A,B} = 00,01,10,11 into one 2-input gate, lets each combination
//   settle for SETTLE_CYCLES cycles, samples Y, and compares the captured
//   truth table against the expected table latched when the sweep started.
//   Optional macro: GATE_SWEEP_ERRCNT_EN adds parameter ERR_W and the
//   saturating err_count output (failing sweeps since reset).
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start         sweep request, accepted only in IDLE
//   expected_tt   expected Y, bit i = Y for A=i[1], B=i[0]
//   gate_a/gate_b gate inputs (0 outside the sweep)
//   gate_y        gate output
//   busy          high in DRIVE, SAMPLE, FINISH
//   done          one-cycle pulse in FINISH
//   pass          result_tt == expected, valid from done until next start
//   result_tt     captured Y per combination
//   mismatch      result_tt ^ expected, held like pass
//   err_count     failing sweeps, saturating (macro only)
// -----------------------------------------------------------------------------
module gate_sweep_ctrl
   import gate_sweep_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2
`ifdef GATE_SWEEP_ERRCNT_EN
   ,
   parameter int ERR_W = 8
`endif
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [NUM_COMBOS-1:0] expected_tt,
   output logic                  gate_a,
   output logic                  gate_b,
   input  logic                  gate_y,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [NUM_COMBOS-1:0] result_tt,
   output logic [NUM_COMBOS-1:0] mismatch
`ifdef GATE_SWEEP_ERRCNT_EN
   ,
   output logic [ERR_W-1:0]      err_count
`endif
);

   sweep_state_e          state_q, state_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [NUM_COMBOS-1:0] exp_q, exp_d;
   logic [NUM_COMBOS-1:0] result_q, result_d;
   logic [NUM_COMBOS-1:0] mismatch_q, mismatch_d;
   logic                  pass_q, pass_d;
   logic                  settle_expired;
   logic                  driving;

   settle_timer #(
      .SETTLE_CYCLES (SETTLE_CYCLES)
   ) u_settle_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (state_q != DRIVE),
      .enable  (state_q == DRIVE),
      .expired (settle_expired)
   );

   assign driving   = (state_q == DRIVE) || (state_q == SAMPLE);
   assign gate_a    = driving & idx_q[1];
   assign gate_b    = driving & idx_q[0];
   assign busy      = (state_q != IDLE);
   assign done      = (state_q == FINISH);
   assign pass      = pass_q;
   assign result_tt = result_q;
   assign mismatch  = mismatch_q;

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      exp_d      = exp_q;
      result_d   = result_q;
      pass_d     = pass_q;
      mismatch_d = mismatch_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               exp_d      = expected_tt;
               idx_d      = '0;
               result_d   = '0;
               pass_d     = 1'b0;
               mismatch_d = '0;
               state_d    = DRIVE;
            end
         end
         DRIVE: begin
            if (settle_expired) begin
               state_d = SAMPLE;
            end
         end
         SAMPLE: begin
            result_d[idx_q] = gate_y;
            if (idx_q == LAST_IDX) begin
               // Compare against the table including the bit captured now,
               // so pass/mismatch are already valid while done is high.
               pass_d     = (result_d == exp_q);
               mismatch_d = result_d ^ exp_q;
               state_d    = FINISH;
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = DRIVE;
            end
         end
         FINISH: begin
            idx_d   = '0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         exp_q      <= '0;
         result_q   <= '0;
         pass_q     <= 1'b0;
         mismatch_q <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         exp_q      <= exp_d;
         result_q   <= result_d;
         pass_q     <= pass_d;
         mismatch_q <= mismatch_d;
      end
   end

`ifdef GATE_SWEEP_ERRCNT_EN
   logic [ERR_W-1:0] err_q, err_d;

   always_comb begin
      err_d = err_q;
      if ((state_q == FINISH) && !pass_q && (err_q != '1)) begin
         err_d = err_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= '0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err_count = err_q;
`endif

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_gate_sweep_ctrl
//   Directed bench for gate_sweep_ctrl. Two instances share clk/rst:
//   dut2 (SETTLE_CYCLES=2) and dut1 (SETTLE_CYCLES=1, ERR_W=2 when the
//   GATE_SWEEP_ERRCNT_EN macro is defined). Each drives a behavioural gate
//   whose function (AND / OR / tied-0) is selected per test.
//   Inputs change and outputs are sampled on the falling edge; edge numbers
//   count the rising edge that accepts start as edge 1.
// -----------------------------------------------------------------------------
module tb_gate_sweep_ctrl;

   localparam int M_AND  = 0;
   localparam int M_OR   = 1;
   localparam int M_ZERO = 2;

   logic clk = 1'b0;
   logic rst;

   logic       start2, gate_a2, gate_b2, gate_y2, busy2, done2, pass2;
   logic [3:0] exp2, result2, mismatch2;
   logic       start1, gate_a1, gate_b1, gate_y1, busy1, done1, pass1;
   logic [3:0] exp1, result1, mismatch1;
`ifdef GATE_SWEEP_ERRCNT_EN
   logic [7:0] err2;
   logic [1:0] err1;
`endif

   int mode2, mode1;
   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   function automatic logic gate_fn(input int mode, input logic a, input logic b);
      case (mode)
         M_AND:   return a & b;
         M_OR:    return a | b;
         default: return 1'b0;
      endcase
   endfunction

   assign gate_y2 = gate_fn(mode2, gate_a2, gate_b2);
   assign gate_y1 = gate_fn(mode1, gate_a1, gate_b1);

   gate_sweep_ctrl #(
      .SETTLE_CYCLES (2)
   ) dut2 (
      .clk         (clk),
      .rst         (rst),
      .start       (start2),
      .expected_tt (exp2),
      .gate_a      (gate_a2),
      .gate_b      (gate_b2),
      .gate_y      (gate_y2),
      .busy        (busy2),
      .done        (done2),
      .pass        (pass2),
      .result_tt   (result2),
      .mismatch    (mismatch2)
`ifdef GATE_SWEEP_ERRCNT_EN
      ,
      .err_count   (err2)
`endif
   );

   gate_sweep_ctrl #(
      .SETTLE_CYCLES (1)
`ifdef GATE_SWEEP_ERRCNT_EN
      ,
      .ERR_W         (2)
`endif
   ) dut1 (
      .clk         (clk),
      .rst         (rst),
      .start       (start1),
      .expected_tt (exp1),
      .gate_a      (gate_a1),
      .gate_b      (gate_b1),
      .gate_y      (gate_y1),
      .busy        (busy1),
      .done        (done1),
      .pass        (pass1),
      .result_tt   (result1),
      .mismatch    (mismatch1)
`ifdef GATE_SWEEP_ERRCNT_EN
      ,
      .err_count   (err1)
`endif
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Pulse start2 for one cycle, then run n edges; report first done edge
   // (0 if none) and the number of done cycles seen.
   task automatic sweep2(input logic [3:0] exp_tt, input int n, output int first_done, output int ndone);
      first_done = 0;
      ndone      = 0;
      exp2   = exp_tt;
      start2 = 1'b1;
      for (int e = 1; e <= n; e++) begin
         @(negedge clk);
         start2 = 1'b0;
         if (done2) begin
            ndone++;
            if (first_done == 0) first_done = e;
         end
      end
   endtask

   initial begin
      int d_edge, n_done, n_busy, n_idle;
      int done_edges[5];

      rst = 1'b1;
      start2 = 1'b0; exp2 = 4'h0; mode2 = M_AND;
      start1 = 1'b0; exp1 = 4'h0; mode1 = M_OR;
      repeat (2) @(negedge clk);

      // ---- reset state ----
      chk("rst_busy", busy2, 1'b0);
      chk("rst_done", done2, 1'b0);
      chk("rst_pass", pass2, 1'b0);
      chk("rst_ab", {gate_a2, gate_b2}, 2'b00);
      chk("rst_result", result2, 4'h0);
      chk("rst_mismatch", mismatch2, 4'h0);
`ifdef GATE_SWEEP_ERRCNT_EN
      chk("rst_err", err2, 8'd0);
`endif
      rst = 1'b0;
      @(negedge clk);

      // ---- test 1: AND gate, expected 1000, full edge-by-edge trace ----
      mode2 = M_AND; exp2 = 4'b1000; start2 = 1'b1;
      for (int e = 1; e <= 12; e++) begin
         @(negedge clk);
         start2 = 1'b0;
         // combo k is driven after edges 3k+1 .. 3k+3 (2 DRIVE + 1 SAMPLE)
         chk($sformatf("t1_ab_e%0d", e), {gate_a2, gate_b2}, 8'((e - 1) / 3));
         chk($sformatf("t1_busy_e%0d", e), busy2, 1'b1);
         chk($sformatf("t1_done_e%0d", e), done2, 1'b0);
      end
      @(negedge clk);
      chk("t1_done_e13", done2, 1'b1);
      chk("t1_busy_e13", busy2, 1'b1);
      chk("t1_ab_e13", {gate_a2, gate_b2}, 2'b00);
      chk("t1_pass", pass2, 1'b1);
      chk("t1_result", result2, 4'b1000);
      chk("t1_mismatch", mismatch2, 4'b0000);
      @(negedge clk);
      chk("t1_done_e14", done2, 1'b0);
      chk("t1_busy_e14", busy2, 1'b0);
      chk("t1_pass_held", pass2, 1'b1);

      // ---- test 2: gate tied 0, expected 1000 -> fail ----
      mode2 = M_ZERO;
      sweep2(4'b1000, 13, d_edge, n_done);
      chk("t2_done_edge", 8'(d_edge), 8'd13);
      chk("t2_pass", pass2, 1'b0);
      chk("t2_mismatch", mismatch2, 4'b1000);
      chk("t2_result", result2, 4'b0000);
      @(negedge clk);
`ifdef GATE_SWEEP_ERRCNT_EN
      chk("t2_err", err2, 8'd1);
`endif

      // ---- test 3: second start pulse at edge 5 is ignored ----
      mode2 = M_AND; exp2 = 4'b1000; start2 = 1'b1;
      n_done = 0; d_edge = 0;
      for (int e = 1; e <= 30; e++) begin
         @(negedge clk);
         start2 = (e == 4);
         if (done2) begin
            n_done++;
            d_edge = e;
         end
      end
      chk("t3_ndone", 8'(n_done), 8'd1);
      chk("t3_done_edge", 8'(d_edge), 8'd13);
      chk("t3_busy_end", busy2, 1'b0);
      chk("t3_pass", pass2, 1'b1);

      // ---- test 4: reset at edge 7 aborts, then a clean sweep ----
      sweep2(4'b1000, 6, d_edge, n_done);
      chk("t4_busy_pre", busy2, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t4_busy_rst", busy2, 1'b0);
      chk("t4_ab_rst", {gate_a2, gate_b2}, 2'b00);
      chk("t4_result_rst", result2, 4'h0);
      chk("t4_pass_rst", pass2, 1'b0);
      n_done = 0; n_busy = 0;
      for (int e = 0; e < 15; e++) begin
         @(negedge clk);
         if (done2) n_done++;
         if (busy2) n_busy++;
      end
      chk("t4_no_done", 8'(n_done), 8'd0);
      chk("t4_no_busy", 8'(n_busy), 8'd0);
      sweep2(4'b1000, 13, d_edge, n_done);
      chk("t4_done_edge", 8'(d_edge), 8'd13);
      chk("t4_pass", pass2, 1'b1);
      chk("t4_result", result2, 4'b1000);

      // ---- test 5: OR gate, SETTLE_CYCLES=1, expected 1110 ----
`ifdef GATE_SWEEP_ERRCNT_EN
      chk("t5_err_start", err1, 2'd0);
`endif
      mode1 = M_OR; exp1 = 4'b1110; start1 = 1'b1;
      for (int e = 1; e <= 8; e++) begin
         @(negedge clk);
         start1 = 1'b0;
         chk($sformatf("t5_ab_e%0d", e), {gate_a1, gate_b1}, 8'((e - 1) / 2));
         chk($sformatf("t5_done_e%0d", e), done1, 1'b0);
      end
      @(negedge clk);
      chk("t5_done_e9", done1, 1'b1);
      chk("t5_pass", pass1, 1'b1);
      chk("t5_result", result1, 4'b1110);
      chk("t5_mismatch", mismatch1, 4'b0000);
      @(negedge clk);

      // ---- test 6: five failing back-to-back sweeps, start held high ----
      mode1 = M_ZERO; exp1 = 4'b1110; start1 = 1'b1;
      n_done = 0; n_idle = 0;
      for (int e = 1; e <= 80 && n_done < 5; e++) begin
         @(negedge clk);
         if (n_done > 0 && !busy1) n_idle++;
         if (done1) begin
            done_edges[n_done] = e;
            chk($sformatf("t6_pass_%0d", n_done), pass1, 1'b0);
            n_done++;
         end
      end
      start1 = 1'b0;
      chk("t6_ndone", 8'(n_done), 8'd5);
      chk("t6_first_done", 8'(done_edges[0]), 8'd9);
      for (int k = 1; k < 5; k++) begin
         // FINISH, one IDLE, accept, 8 sweep edges -> 10 edges apart
         chk($sformatf("t6_gap_%0d", k), 8'(done_edges[k] - done_edges[k-1]), 8'd10);
      end
      chk("t6_idle_cycles", 8'(n_idle), 8'd4);
      @(negedge clk);
      @(negedge clk);
      chk("t6_idle_after", busy1, 1'b0);
      chk("t6_mismatch", mismatch1, 4'b1110);
`ifdef GATE_SWEEP_ERRCNT_EN
      chk("t6_err_sat", err1, 2'd3);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
